lockin_lpf_decim: RTL and testbench

- Low-pass and decimation stage directly downstream of the lock-in mixer.
- Consumes the 32-bit signed mixer product, which arrives one sample per enabled clock.
- Stage 1 is a power-of-two accumulate-and-dump. Stage 2 is a first-order IIR with a programmable shift. The output is scaled and saturated to OW bits with a valid strobe.
- Output feeds the servo/readout logic at the decimated rate.

---
 rtl/lockin_lpf_decim.sv | 135 +++++++++++++
 tb/tb_lockin_lpf_decim.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lockin_lpf_decim.sv
// Lock-in post-mixer filter: power-of-two accumulate-and-dump, first-order IIR,
// then arithmetic scaling and saturation to OW bits with a one-cycle valid strobe.
module lockin_lpf_decim #(
    parameter int IW     = 32,
    parameter int OW     = 24,
    parameter int MAXLOG = 8,
    parameter int KMAX   = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clear_in,
    input  logic                 valid_in,
    input  logic signed [IW-1:0] signal_in,
    input  logic [3:0]           log_n_in,
    input  logic [4:0]           k_in,
    input  logic [3:0]           out_shift_in,
    output logic signed [OW-1:0] signal_out,
    output logic                 valid_out,
    output logic                 ovf_out
);

    localparam int AW = IW + MAXLOG;
    localparam int SW = IW + KMAX + 1;
    localparam logic [3:0] MAXLOG_L = 4'(MAXLOG);
    localparam logic [4:0] KMAX_L   = 5'(KMAX);
    localparam logic signed [IW:0] Z_MAX = (IW+1)'((1 << (OW - 1)) - 1);
    localparam logic signed [IW:0] Z_MIN = ~Z_MAX;

    logic signed [AW-1:0] acc;
    logic [MAXLOG-1:0]    cnt;
    logic [3:0]           log_lat;
    logic signed [IW-1:0] dump;
    logic                 dump_v;
    logic signed [SW-1:0] s;
    logic                 s_v;

    logic [3:0]           log_clamp;
    logic [3:0]           cur_log;
    logic [4:0]           k_c;
    logic [MAXLOG:0]      n_m1;
    logic                 last;
    logic signed [AW-1:0] sum;
    logic signed [SW-1:0] target;
    logic signed [SW:0]   diff;
    logic signed [IW:0]   y;
    logic signed [IW:0]   z;

    // Block length comes from the live input only at block start; otherwise from the latch.
    always_comb begin
        log_clamp = (log_n_in > MAXLOG_L) ? MAXLOG_L : log_n_in;
        cur_log   = (cnt == '0) ? log_clamp : log_lat;
        k_c       = (k_in > KMAX_L) ? KMAX_L : k_in;
        n_m1      = ((MAXLOG+1)'(1) << cur_log) - (MAXLOG+1)'(1);
        last      = ({1'b0, cnt} == n_m1);
        sum       = acc + {{MAXLOG{signal_in[IW-1]}}, signal_in};
        target    = {dump[IW-1], dump, {KMAX{1'b0}}};
        diff      = {target[SW-1], target} - {s[SW-1], s};
        y         = s[SW-1:KMAX];
        z         = y >>> out_shift_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc     <= '0;
            cnt     <= '0;
            log_lat <= '0;
            dump    <= '0;
            dump_v  <= 1'b0;
        end else if (clear_in) begin
            acc     <= '0;
            cnt     <= '0;
            log_lat <= '0;
            dump    <= '0;
            dump_v  <= 1'b0;
        end else begin
            dump_v <= 1'b0;
            if (cnt == '0) begin
                log_lat <= log_clamp;
            end
            if (valid_in) begin
                if (last) begin
                    dump   <= IW'(sum >>> cur_log);
                    dump_v <= 1'b1;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + MAXLOG'(1);
                end
            end
        end
    end

    // IIR state carries KMAX fractional bits; k = 0 loads the target directly.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s   <= '0;
            s_v <= 1'b0;
        end else if (clear_in) begin
            s   <= '0;
            s_v <= 1'b0;
        end else begin
            s_v <= dump_v;
            if (dump_v) begin
                s <= s + SW'(diff >>> k_c);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            signal_out <= '0;
            valid_out  <= 1'b0;
            ovf_out    <= 1'b0;
        end else if (clear_in) begin
            signal_out <= '0;
            valid_out  <= 1'b0;
            ovf_out    <= 1'b0;
        end else begin
            valid_out <= s_v;
            if (s_v) begin
                if (z > Z_MAX) begin
                    signal_out <= {1'b0, {(OW-1){1'b1}}};
                    ovf_out    <= 1'b1;
                end else if (z < Z_MIN) begin
                    signal_out <= {1'b1, {(OW-1){1'b0}}};
                    ovf_out    <= 1'b1;
                end else begin
                    signal_out <= OW'(z);
                end
            end
        end
    end

endmodule

// File: tb/tb_lockin_lpf_decim.sv
// Bench for lockin_lpf_decim: directed and random steps, each cycle compared
// against an arithmetic model of block averaging, IIR smoothing and saturation.
module tb_lockin_lpf_decim;

    logic        clk_in;
    logic        rst_in;
    logic        clear_in;
    logic        valid_in;
    logic [31:0] signal_in;
    logic [3:0]  log_n_in;
    logic [4:0]  k_in;
    logic [3:0]  out_shift_in;
    logic [23:0] signal_out;
    logic        valid_out;
    logic        ovf_out;

    lockin_lpf_decim dut (
        .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in), .valid_in(valid_in),
        .signal_in(signal_in), .log_n_in(log_n_in), .k_in(k_in),
        .out_shift_in(out_shift_in), .signal_out(signal_out),
        .valid_out(valid_out), .ovf_out(ovf_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          due;
        logic [23:0] val;
        logic        sat;
    } ent_t;

    longint      blk[$];
    int          blk_log;
    longint      s_m;
    int          cyc = 0;
    ent_t        pend[$];
    logic [23:0] last_out;
    logic        ovf_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        blk.delete();
        s_m = 0;
        pend.delete();
        last_out = '0;
        ovf_m = 1'b0;
    endtask

    task automatic accept(input longint x);
        longint sum, n, avg, y, z;
        int     k;
        ent_t   e;
        if (blk.size() == 0) blk_log = (log_n_in > 8) ? 8 : int'(log_n_in);
        blk.push_back(x);
        n = longint'(1) << blk_log;
        if (blk.size() == n) begin
            sum = 0;
            foreach (blk[i]) sum += blk[i];
            avg = floor_div(sum, n);
            k = (k_in > 16) ? 16 : int'(k_in);
            s_m = s_m + floor_div(avg * 65536 - s_m, longint'(1) << k);
            y = floor_div(s_m, 65536);
            z = floor_div(y, longint'(1) << out_shift_in);
            e.due = cyc + 2;
            e.sat = 1'b1;
            if (z > 8388607) e.val = 24'h7FFFFF;
            else if (z < -8388608) e.val = 24'h800000;
            else begin
                e.val = 24'(z);
                e.sat = 1'b0;
            end
            pend.push_back(e);
            blk.delete();
        end
    endtask

    task automatic step(input logic v, input logic [31:0] x, input logic clr);
        logic exp_v;
        @(negedge clk_in);
        valid_in  = v;
        signal_in = x;
        clear_in  = clr;
        @(posedge clk_in);
        cyc++;
        exp_v = 1'b0;
        if (clr) model_clear();
        else if (v) accept(longint'($signed(x)));
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_v    = 1'b1;
            last_out = pend[0].val;
            ovf_m    = ovf_m | pend[0].sat;
            pend.delete(0);
        end
        #1;
        chk("valid_out", {63'd0, valid_out}, {63'd0, exp_v});
        chk("signal_out", {40'd0, signal_out}, {40'd0, last_out});
        chk("ovf_out", {63'd0, ovf_out}, {63'd0, ovf_m});
    endtask

    task automatic flush();
        repeat (4) step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in   = 1'b0;
        valid_in = 1'b0;
        clear_in = 1'b0;
        #1;
        chk("rst_signal_out", {40'd0, signal_out}, 64'd0);
        chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
        chk("rst_ovf_out", {63'd0, ovf_out}, 64'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_clear();
    endtask

    function automatic logic [31:0] rand_sample();
        if ($urandom_range(0, 2) == 0) return $urandom();
        return 32'($signed($urandom_range(0, 4000)) - 2000);
    endfunction

    initial begin
        rst_in = 1'b0; clear_in = 1'b0; valid_in = 1'b0; signal_in = '0;
        log_n_in = 4'd2; k_in = 5'd0; out_shift_in = 4'd0;
        model_clear();
        do_reset();

        // reset in the middle of a block with a nonzero accumulator
        step(1'b1, 32'd7, 1'b0);
        step(1'b1, 32'd7, 1'b0);
        do_reset();
        repeat (4) step(1'b1, 32'd5, 1'b0);
        flush();
        chk("after_reset_avg5", {40'd0, signal_out}, 64'd5);

        // plain averaging, then floor on negatives with gapped valid_in
        step(1'b1, 32'd1, 1'b0); step(1'b1, 32'd2, 1'b0);
        step(1'b1, 32'd3, 1'b0); step(1'b1, 32'd6, 1'b0);
        flush();
        chk("avg_1236", {40'd0, signal_out}, 64'd3);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 3) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 1'b0);
            repeat ($urandom_range(0, 3)) step(1'b0, $urandom(), 1'b0);
        end
        flush();
        chk("avg_floor_neg", {40'd0, signal_out}, 64'hFF_FFFE);

        // IIR step response, then k = 0 bypass
        step(1'b0, 32'd0, 1'b1);
        log_n_in = 4'd0; k_in = 5'd1;
        repeat (4) step(1'b1, 32'd1024, 1'b0);
        flush();
        chk("iir_step_4th", {40'd0, signal_out}, 64'd960);
        k_in = 5'd0;
        step(1'b1, 32'd1024, 1'b0);
        flush();
        chk("iir_bypass", {40'd0, signal_out}, 64'd1024);

        // saturation and sticky overflow
        step(1'b0, 32'd0, 1'b1);
        step(1'b1, 32'h4000_0000, 1'b0);
        flush();
        chk("sat_hi", {40'd0, signal_out}, 64'h7F_FFFF);
        chk("sat_hi_ovf", {63'd0, ovf_out}, 64'd1);
        step(1'b1, 32'hC000_0000, 1'b0);
        flush();
        chk("sat_lo", {40'd0, signal_out}, 64'h80_0000);
        step(1'b1, 32'd0, 1'b0);
        flush();
        chk("ovf_sticky", {63'd0, ovf_out}, 64'd1);
        step(1'b0, 32'd0, 1'b1);
        chk("ovf_cleared", {63'd0, ovf_out}, 64'd0);

        // block length change mid-block takes effect on the next block
        log_n_in = 4'd2;
        step(1'b1, 32'd10, 1'b0); step(1'b1, 32'd20, 1'b0);
        log_n_in = 4'd3;
        step(1'b1, 32'd30, 1'b0); step(1'b1, 32'd40, 1'b0);
        repeat (8) step(1'b1, rand_sample(), 1'b0);
        flush();

        // clear coincident with the last sample of a block
        log_n_in = 4'd2;
        repeat (3) step(1'b1, 32'd100, 1'b0);
        step(1'b1, 32'd100, 1'b1);
        repeat (4) step(1'b1, 32'd8, 1'b0);
        flush();
        chk("clear_then_fresh", {40'd0, signal_out}, 64'd8);

        // N = 1 continuous throughput
        log_n_in = 4'd0; k_in = 5'd2;
        repeat (20) step(1'b1, rand_sample(), 1'b0);
        flush();

        // clamped block length and IIR shift
        step(1'b0, 32'd0, 1'b1);
        log_n_in = 4'd15; k_in = 5'd31; out_shift_in = 4'd4;
        repeat (260) step(1'b1, rand_sample(), 1'b0);
        flush();

        // random blocks, parameters, gaps and clears
        for (int it = 0; it < 30; it++) begin
            flush();
            k_in = 5'($urandom_range(0, 6));
            out_shift_in = 4'($urandom_range(0, 9));
            repeat ($urandom_range(1, 24)) begin
                if ($urandom_range(0, 9) == 0) log_n_in = 4'($urandom_range(0, 3));
                step(($urandom_range(0, 9) < 7), rand_sample(), ($urandom_range(0, 39) == 0));
            end
        end
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
